// File: rtl/if_queue_pkg.sv
// Shared widths for the instruction-fetch queue slice.
// Stands in for the codebase-wide PC/word width defines.
package if_queue_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/if_queue_if.sv
// Fetch-side request/response and decode-side valid/ready bundle.
// master = PC generator, memory and decode; slave = the queue.
interface if_queue_if #(
    parameter int PC_W   = 32,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 3
);
    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic              req_ready;
    logic [INSN_W-1:0] mem_insn;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INSN_W-1:0] out_insn;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        output req_valid, req_pc, mem_insn, out_ready,
        input  req_ready, out_valid, out_pc, out_insn, count
    );

    modport slave (
        input  req_valid, req_pc, mem_insn, out_ready,
        output req_ready, out_valid, out_pc, out_insn, count
    );
endinterface

// File: rtl/if_queue_ram.sv
// DEPTH-entry register array, one write port, combinational read.
// Contents are deliberately left unreset.
module if_queue_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_queue.sv
// Fetch queue of {pc, insn}: 1-cycle bypass when empty, else head 2 cycles after accept.
// req_ready reserves a slot for the in-flight read; decode backpressure via out_ready.
module if_queue
    import if_queue_pkg::*;
#(
    parameter int PC_W   = PC_WIDTH,
    parameter int INSN_W = WORD_WIDTH,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      cpu_en,
    input  logic      flush,
    if_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + INSN_W;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt_r;
    logic             inflight_r;
    logic [PC_W-1:0]  inflight_pc_r;
    logic [EW-1:0]    head_dat;

    logic empty;
    logic byp_ok;
    logic accept;
    logic deq;
    logic byp_take;
    logic pop;
    logic enq;

    assign empty  = (cnt_r == '0);
    assign byp_ok = (BYPASS != 0) && empty && inflight_r && !flush;

    // Occupancy only, never out_ready: a same-cycle dequeue does not reopen the request side.
    assign bus.req_ready = cpu_en && !flush &&
        (({1'b0, cnt_r} + (CNT_W+1)'(inflight_r)) < (CNT_W+1)'(DEPTH));
    assign accept = bus.req_valid && bus.req_ready;

    assign bus.out_valid = cpu_en && !flush && (!empty || byp_ok);
    assign deq           = bus.out_valid && bus.out_ready && cpu_en;
    assign byp_take      = deq && empty;
    assign pop           = deq && !empty;
    assign enq           = inflight_r && !flush && !byp_take;

    always_comb begin
        bus.out_pc   = '0;
        bus.out_insn = '0;
        if (bus.out_valid) begin
            if (empty) begin
                bus.out_pc   = inflight_pc_r;
                bus.out_insn = bus.mem_insn;
            end else begin
                {bus.out_pc, bus.out_insn} = head_dat;
            end
        end
    end

    assign bus.count = cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt_r         <= '0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_r      <= '0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= accept;
            if (accept) begin
                inflight_pc_r <= bus.req_pc;
            end
            wr_ptr <= wr_ptr + AW'(enq);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt_r  <= cnt_r + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    if_queue_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (enq && rst_n),
        .waddr (wr_ptr),
        .wdata ({inflight_pc_r, bus.mem_insn}),
        .raddr (rd_ptr),
        .rdata (head_dat)
    );
endmodule

// File: doc/if_queue.md
# if_queue

Parametrised instruction-fetch queue between the PC generator / instruction memory and decode. It replaces the single-entry IF register and its one-entry stall buffer with a DEPTH-entry FIFO that holds {pc, insn} pairs. It tracks the one-cycle memory read latency, so returning words are never lost under backpressure, and a flush squashes both the stored entries and the in-flight read. Decode consumes entries through a valid/ready handshake instead of a stall line.

## Interface
- PC_W, default `PC_WIDTH: PC width.
- INSN_W, default `WORD_WIDTH: instruction width.
- DEPTH, default 4: queue entries; power of two, ≥2.
- BYPASS, default 1: 1 presents an arriving word to decode in the same cycle when the queue is empty.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- cpu_en  in  1  global enable. Low blocks request accept and dequeue.
- flush  in  1  squash all queued and in-flight fetches.
- req_valid  in  1  PC generator offers req_pc. The address goes to memory externally in the same cycle.
- req_pc  in  PC_W  fetch address.
- req_ready  out  1  a request may be accepted this cycle.
- mem_insn  in  INSN_W  memory read data. Valid exactly one cycle after an accepted request.
- out_valid  out  1  decode entry valid.
- out_pc  out  PC_W  pc of head entry.
- out_insn  out  INSN_W  instruction of head entry.
- out_ready  in  1  decode accepts the head entry.
- count  out  CNT_W  stored entries, excluding the in-flight read.

## Operation
- Accept = req_valid & req_ready.
- req_ready = cpu_en & !flush & (count + inflight_r < DEPTH). Space is reserved for the in-flight word, so an arriving word always has a slot.
- On accept, set inflight_r = 1 and inflight_pc_r = req_pc. If there is no accept, inflight_r = 0. At most one read is outstanding per cycle, and back-to-back accepts are allowed.
- Arrival: in the cycle after an accept (inflight_r = 1), the pair {inflight_pc_r, mem_insn} is enqueued. It is enqueued even when cpu_en = 0.
- Bypass (BYPASS = 1, queue empty, inflight_r = 1, flush = 0):
  - out_valid = cpu_en.
  - out_pc = inflight_pc_r, out_insn = mem_insn.
  - If out_ready & cpu_en, the word is consumed and not written.
- Dequeue: out_valid & out_ready & cpu_en. Advance the read pointer.
- out_valid = cpu_en & !flush & (count != 0 | bypass-eligible).
- When out_valid = 0, out_pc and out_insn are driven to 0.
- Simultaneous enqueue and dequeue with a non-empty queue: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is an explicit counter, saturating arithmetic is not used, and it never exceeds DEPTH.
- Flush has priority over everything and is independent of cpu_en. In the flush cycle:
  - Clear count and both pointers; clear inflight_r.
  - Discard the word arriving that cycle.
  - Force req_ready = 0 and out_valid = 0.
- Reset (rst_n = 0 at an edge), including mid-operation: same effect as flush, and additionally inflight_pc_r = 0. Storage contents need no reset.

## Timing
- Reset values: out_valid 0, out_pc 0, out_insn 0, count 0, inflight_r 0. req_ready = cpu_en after reset.
- Latency from accept at cycle t:
  - Bypass with empty queue: out_valid in cycle t+1.
  - Otherwise: the entry is stored at the end of t+1 and is visible at the head in t+2 if ahead of nothing.
- Throughput is one instruction per cycle sustained when decode is always ready.
- Full boundary:
  - count = DEPTH-1 with inflight_r = 1 → req_ready = 0.
  - A dequeue in the same cycle does not re-open req_ready (conservative, no combinational path from out_ready to req_ready).
- Empty boundary: with no inflight word, out_valid = 0.
- No combinational path from req_valid to out_*.

## Structure
- PC_WIDTH and WORD_WIDTH come from the shared defines header. No new shared typedefs are required.
- One sub-module: if_queue_ram, a DEPTH×(PC_W+INSN_W) register array with 1 write port and a combinational read. The control logic (pointers, count, inflight, bypass mux) stays in if_queue.

## Test plan
- Reset, then 8 back-to-back requests pc = 0x00, 0x04, … with out_ready = 1 and BYPASS = 1 → out_valid from cycle 1 onward, out_pc sequence 0x00…0x1C, count stays 0.
- out_ready = 0 and issue requests at 0x100, 0x104, … → req_ready drops after 4 accepts; count reaches 4; no word lost. Then out_ready = 1 → dequeue order 0x100, 0x104, 0x108, 0x10C.
- Flush in the cycle a word for pc 0x20 arrives, with count = 2 → next cycle count = 0 and out_valid = 0; 0x20 is never presented.
- cpu_en = 0 in the cycle after accepting pc 0x40 → word stored, count = 1, out_valid = 0. cpu_en = 1 → out_pc = 0x40.
- Wrap: alternate enqueue and dequeue for 3×DEPTH entries → pc order is preserved across pointer wrap, and count never exceeds DEPTH.
- rst_n low for one cycle mid-stream with count = 3 and inflight_r = 1 → all outputs return to their reset values, and the word arriving after reset is ignored.
